pipeline_ctrl: RTL and testbench

Central stall/flush controller for the five-stage pipeline. It drives the write-enables and bubble-inject (flush) controls of the PC, F/D, D/X, X/M and M/W latches. It detects load-use hazards between F/D and D/X and resolves taken branches and jumps. It sequences the multi-cycle multiplier/divider while holding the front of the pipeline.

---
 rtl/pipeline_ctrl_pkg.sv | 33 +++
 rtl/pipeline_ctrl_md_wait_counter.sv | 31 +++
 rtl/pipeline_ctrl.sv | 121 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants and types for the pipeline stall/flush controller.
// Opcode/ALU encodings, FSM state type and the latch-control bundle.
package pipeline_ctrl_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic pc_we;
        logic fd_we;
        logic dx_we;
        logic xm_we;
        logic mw_we;
        logic fd_flush;
        logic dx_flush;
        logic xm_flush;
    } latch_ctrl_t;

    // Bit order: pc, fd, dx, xm, mw write-enables, then fd, dx, xm flushes.
    localparam latch_ctrl_t CTRL_IDLE     = latch_ctrl_t'(8'b00000_000);
    localparam latch_ctrl_t CTRL_ADVANCE  = latch_ctrl_t'(8'b11111_000);
    localparam latch_ctrl_t CTRL_BRANCH   = latch_ctrl_t'(8'b11111_110);
    localparam latch_ctrl_t CTRL_LOAD_USE = latch_ctrl_t'(8'b00111_010);
    localparam latch_ctrl_t CTRL_MD_HOLD  = latch_ctrl_t'(8'b00011_001);

endpackage

// File: rtl/pipeline_ctrl_md_wait_counter.sv
// Counts cycles spent waiting on the multiplier/divider.
// terminal is high once the count has reached MD_TIMEOUT-1.
module md_wait_counter #(
    parameter int MD_TIMEOUT = 40
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [W-1:0] LAST = W'(MD_TIMEOUT - 1);

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != LAST) begin
            count <= count + W'(1);
        end
    end

    assign terminal = (count == LAST);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the five-stage pipeline: load-use stalls,
// taken-branch flushes and multiplier/divider sequencing.
import pipeline_ctrl_pkg::*;

module pipeline_ctrl #(
    parameter int MD_TIMEOUT = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  fd_opcode,
    input  logic [4:0]  fd_rs,
    input  logic [4:0]  fd_rt,
    input  logic [4:0]  dx_opcode,
    input  logic [4:0]  dx_aluop,
    input  logic [4:0]  dx_rd,
    input  logic        branch_taken,
    input  logic        md_ready,
    output logic        pc_we,
    output logic        fd_we,
    output logic        dx_we,
    output logic        xm_we,
    output logic        mw_we,
    output logic        fd_flush,
    output logic        dx_flush,
    output logic        xm_flush,
    output logic        md_start,
    output logic        md_busy,
    output logic        md_error,
    output logic [31:0] stall_count
);

    state_t      state;
    latch_ctrl_t ctrl;
    logic        multdiv_in_dx;
    logic        load_use;
    logic        cnt_terminal;
    logic        md_release;
    logic        md_timeout;

    // fd_opcode is carried for interface completeness; hazards depend only on the registers.
    logic unused_fd_opcode;
    assign unused_fd_opcode = ^fd_opcode;

    assign multdiv_in_dx = (dx_opcode == OP_RTYPE) &&
                           (dx_aluop == ALU_MUL || dx_aluop == ALU_DIV);
    assign load_use      = (dx_opcode == OP_LW) && (dx_rd != 5'd0) &&
                           (dx_rd == fd_rs || dx_rd == fd_rt);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        ctrl       = CTRL_IDLE;
        md_start   = 1'b0;
        md_busy    = 1'b0;
        md_release = 1'b0;
        md_timeout = 1'b0;
        if (!reset) begin
            unique case (state)
                RUN: begin
                    if (branch_taken) begin
                        ctrl = CTRL_BRANCH;
                    end else if (multdiv_in_dx) begin
                        ctrl     = CTRL_MD_HOLD;
                        md_start = 1'b1;
                    end else if (load_use) begin
                        ctrl = CTRL_LOAD_USE;
                    end else begin
                        ctrl = CTRL_ADVANCE;
                    end
                end
                MD_WAIT: begin
                    md_busy = 1'b1;
                    if (md_ready || cnt_terminal) begin
                        ctrl       = CTRL_ADVANCE;
                        md_release = 1'b1;
                        md_timeout = !md_ready;
                    end else begin
                        ctrl = CTRL_MD_HOLD;
                    end
                end
                default: ctrl = CTRL_IDLE;
            endcase
        end
    end

    md_wait_counter #(
        .MD_TIMEOUT (MD_TIMEOUT)
    ) u_wait_counter (
        .clock    (clock),
        .reset    (reset),
        .clear    (md_start),
        .enable   (md_busy),
        .terminal (cnt_terminal)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            md_error    <= 1'b0;
            stall_count <= '0;
        end else begin
            unique case (state)
                RUN:     if (md_start)   state <= MD_WAIT;
                MD_WAIT: if (md_release) state <= RUN;
                default: state <= RUN;
            endcase
            if (md_timeout) md_error <= 1'b1;
            if (!ctrl.pc_we && stall_count != 32'hFFFF_FFFF)
                stall_count <= stall_count + 32'd1;
        end
    end

    assign pc_we    = ctrl.pc_we;
    assign fd_we    = ctrl.fd_we;
    assign dx_we    = ctrl.dx_we;
    assign xm_we    = ctrl.xm_we;
    assign mw_we    = ctrl.mw_we;
    assign fd_flush = ctrl.fd_flush;
    assign dx_flush = ctrl.dx_flush;
    assign xm_flush = ctrl.xm_flush;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: vector table, hand-written
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_pipeline_ctrl;

    localparam int MD_TIMEOUT = 40;

    logic        clock;
    logic        reset;
    logic [4:0]  fd_opcode, fd_rs, fd_rt, dx_opcode, dx_aluop, dx_rd;
    logic        branch_taken, md_ready;
    logic        pc_we, fd_we, dx_we, xm_we, mw_we;
    logic        fd_flush, dx_flush, xm_flush;
    logic        md_start, md_busy, md_error;
    logic [31:0] stall_count;

    pipeline_ctrl #(
        .MD_TIMEOUT (MD_TIMEOUT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .fd_opcode    (fd_opcode),
        .fd_rs        (fd_rs),
        .fd_rt        (fd_rt),
        .dx_opcode    (dx_opcode),
        .dx_aluop     (dx_aluop),
        .dx_rd        (dx_rd),
        .branch_taken (branch_taken),
        .md_ready     (md_ready),
        .pc_we        (pc_we),
        .fd_we        (fd_we),
        .dx_we        (dx_we),
        .xm_we        (xm_we),
        .mw_we        (mw_we),
        .fd_flush     (fd_flush),
        .dx_flush     (dx_flush),
        .xm_flush     (xm_flush),
        .md_start     (md_start),
        .md_busy      (md_busy),
        .md_error     (md_error),
        .stall_count  (stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // {pc_we, fd_we, dx_we, xm_we, mw_we, fd_flush, dx_flush, xm_flush, md_start, md_busy}
    function automatic logic [9:0] dut_vec();
        return {pc_we, fd_we, dx_we, xm_we, mw_we, fd_flush, dx_flush, xm_flush, md_start, md_busy};
    endfunction

    localparam logic [9:0] V_ZERO    = 10'b00000_000_00;
    localparam logic [9:0] V_ADV     = 10'b11111_000_00;
    localparam logic [9:0] V_BRANCH  = 10'b11111_110_00;
    localparam logic [9:0] V_LU      = 10'b00111_010_00;
    localparam logic [9:0] V_START   = 10'b00011_001_10;
    localparam logic [9:0] V_WAIT    = 10'b00011_001_01;
    localparam logic [9:0] V_RELEASE = 10'b11111_000_01;

    task automatic set_in(input logic [4:0] fop, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] dop, input logic [4:0] alu, input logic [4:0] rd,
                          input logic br, input logic rdy);
        fd_opcode = fop; fd_rs = rs; fd_rt = rt;
        dx_opcode = dop; dx_aluop = alu; dx_rd = rd;
        branch_taken = br; md_ready = rdy;
    endtask

    task automatic neutral();
        set_in(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        neutral();
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        logic [4:0] fop, rs, rt, dop, alu, rd;
        logic       br, rdy;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[14];

    // Behavioural model: a multdiv-in-flight flag and the number of wait cycles already spent.
    bit      m_md;
    int      m_waited;
    bit      m_err;
    longint  m_stalls;

    function automatic logic [9:0] model_eval(output bit timed_out, output bit enter, output bit leave);
        logic [9:0] e;
        timed_out = 0; enter = 0; leave = 0;
        if (m_md) begin
            if (md_ready || (m_waited + 1 == MD_TIMEOUT)) begin
                e = V_RELEASE; leave = 1; timed_out = !md_ready;
            end else begin
                e = V_WAIT;
            end
        end else if (branch_taken) begin
            e = V_BRANCH;
        end else if (dx_opcode == 5'b00000 && (dx_aluop == 5'b00110 || dx_aluop == 5'b00111)) begin
            e = V_START; enter = 1;
        end else if (dx_opcode == 5'b01000 && dx_rd != 0 && (dx_rd == fd_rs || dx_rd == fd_rt)) begin
            e = V_LU;
        end else begin
            e = V_ADV;
        end
        return e;
    endfunction

    initial begin
        int starts, busys, xmf_wait, waits;
        logic [9:0] e;
        bit to, en, lv;

        // Reset state
        reset = 1'b1;
        neutral();
        @(negedge clock);
        check("reset outputs", dut_vec(), V_ZERO);
        check("reset stall_count", stall_count, 0);
        check("reset md_error", md_error, 0);
        tick();
        reset = 1'b0;

        // Vector table, applied back to back; state carries across rows
        vecs[0]  = '{5'd0, 5'd1, 5'd2, 5'b00000, 5'd0,     5'd5, 1'b0, 1'b0, V_ADV};
        vecs[1]  = '{5'd0, 5'd3, 5'd2, 5'b01000, 5'd0,     5'd3, 1'b0, 1'b0, V_LU};
        vecs[2]  = '{5'd0, 5'd1, 5'd3, 5'b01000, 5'd0,     5'd3, 1'b0, 1'b0, V_LU};
        vecs[3]  = '{5'd0, 5'd0, 5'd0, 5'b01000, 5'd0,     5'd0, 1'b0, 1'b0, V_ADV};
        vecs[4]  = '{5'd0, 5'd3, 5'd3, 5'b01000, 5'd0,     5'd3, 1'b1, 1'b0, V_BRANCH};
        vecs[5]  = '{5'd0, 5'd4, 5'd5, 5'b01000, 5'd0,     5'd3, 1'b0, 1'b0, V_ADV};
        vecs[6]  = '{5'd0, 5'd3, 5'd0, 5'b00000, 5'd0,     5'd3, 1'b0, 1'b0, V_ADV};
        vecs[7]  = '{5'd0, 5'd0, 5'd0, 5'b00000, 5'b00110, 5'd7, 1'b0, 1'b1, V_START};
        vecs[8]  = '{5'd0, 5'd0, 5'd0, 5'b00000, 5'b00110, 5'd7, 1'b0, 1'b1, V_RELEASE};
        vecs[9]  = '{5'd0, 5'd0, 5'd0, 5'b00000, 5'b00110, 5'd7, 1'b1, 1'b0, V_BRANCH};
        vecs[10] = '{5'd0, 5'd0, 5'd0, 5'b00000, 5'b00111, 5'd7, 1'b0, 1'b0, V_START};
        vecs[11] = '{5'd0, 5'd0, 5'd0, 5'b00000, 5'b00111, 5'd7, 1'b1, 1'b0, V_WAIT};
        vecs[12] = '{5'd0, 5'd0, 5'd0, 5'b00000, 5'b00111, 5'd7, 1'b0, 1'b1, V_RELEASE};
        vecs[13] = '{5'd0, 5'd0, 5'd0, 5'b00001, 5'b00110, 5'd7, 1'b0, 1'b0, V_ADV};
        for (int i = 0; i < 14; i++) begin
            set_in(vecs[i].fop, vecs[i].rs, vecs[i].rt, vecs[i].dop, vecs[i].alu, vecs[i].rd,
                   vecs[i].br, vecs[i].rdy);
            @(negedge clock);
            check($sformatf("vector %0d", i), dut_vec(), vecs[i].exp);
            tick();
        end
        @(negedge clock);
        check("vector stall_count", stall_count, 5);

        // Load-use: one stall cycle, then normal advance
        do_reset();
        set_in(5'd0, 5'd3, 5'd1, 5'b01000, 5'd0, 5'd3, 1'b0, 1'b0);
        @(negedge clock);
        check("load-use stall", dut_vec(), V_LU);
        tick();
        neutral();
        @(negedge clock);
        check("load-use next advance", dut_vec(), V_ADV);
        check("load-use stall_count", stall_count, 1);

        // Multdiv released by md_ready on the sixth wait cycle
        do_reset();
        set_in(5'd0, 5'd0, 5'd0, 5'b00000, 5'b00110, 5'd4, 1'b0, 1'b0);
        @(negedge clock);
        check("mul start cycle", dut_vec(), V_START);
        starts = 1; busys = 0; xmf_wait = 0; waits = 0;
        while (waits < 100) begin
            tick();
            waits++;
            md_ready = (waits == 6);
            @(negedge clock);
            starts   += int'(md_start);
            busys    += int'(md_busy);
            if (pc_we) break;
            xmf_wait += int'(xm_flush);
        end
        check("mul release vector", dut_vec(), V_RELEASE);
        check("mul md_start cycles", starts, 1);
        check("mul md_busy cycles", busys, 6);
        check("mul xm_flush wait cycles", xmf_wait, 5);
        tick();
        neutral();
        @(negedge clock);
        check("mul stall_count", stall_count, 6);
        check("mul md_error", md_error, 0);
        check("mul back in run", dut_vec(), V_ADV);

        // Multdiv with md_ready never asserted: forced release and sticky error
        do_reset();
        set_in(5'd0, 5'd0, 5'd0, 5'b00000, 5'b00111, 5'd4, 1'b0, 1'b0);
        @(negedge clock);
        check("div start cycle", dut_vec(), V_START);
        waits = 0;
        while (waits < 200) begin
            tick();
            waits++;
            @(negedge clock);
            if (pc_we) break;
        end
        check("timeout wait cycles", waits, MD_TIMEOUT);
        check("timeout release vector", dut_vec(), V_RELEASE);
        tick();
        neutral();
        @(negedge clock);
        check("timeout md_error set", md_error, 1);
        check("timeout stall_count", stall_count, MD_TIMEOUT);
        for (int i = 0; i < 5; i++) tick();
        @(negedge clock);
        check("timeout md_error sticky", md_error, 1);

        // Reset asserted in the middle of MD_WAIT
        set_in(5'd0, 5'd0, 5'd0, 5'b00000, 5'b00110, 5'd4, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        @(negedge clock);
        check("pre-reset in wait", dut_vec(), V_WAIT);
        #2 reset = 1'b1;
        #1;
        check("mid-wait reset outputs", dut_vec(), V_ZERO);
        check("mid-wait reset stall_count", stall_count, 0);
        check("mid-wait reset md_error", md_error, 0);
        neutral();
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("post-reset run", dut_vec(), V_ADV);
        tick();
        @(negedge clock);
        check("post-reset stall_count", stall_count, 0);

        // Randomized run against the model
        do_reset();
        m_md = 0; m_waited = 0; m_err = 0; m_stalls = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] dop, alu;
            case ($urandom_range(0, 3))
                0:       dop = 5'b00000;
                2:       dop = 5'($urandom_range(0, 31));
                default: dop = 5'b01000;
            endcase
            case ($urandom_range(0, 3))
                0:       alu = 5'b00110;
                1:       alu = 5'b00111;
                default: alu = 5'($urandom_range(0, 31));
            endcase
            set_in(5'($urandom_range(0, 31)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   dop, alu, 5'($urandom_range(0, 3)),
                   $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
            @(negedge clock);
            e = model_eval(to, en, lv);
            check("random controls", dut_vec(), e);
            check("random md_error", md_error, m_err);
            check("random stall_count", stall_count, m_stalls);
            if (e[9] == 1'b0 && m_stalls < 64'hFFFF_FFFF) m_stalls++;
            if (to) m_err = 1;
            if (en) begin m_md = 1; m_waited = 0; end
            else if (lv) m_md = 0;
            else if (m_md) m_waited++;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
